// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - Avalon-MM system-ID read/compare sequencer.
// Optional per-read abort counter enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1463451056,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        in_xfer;
    logic        data_wins;
    logic        timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d       = state_q;
        auto_d        = auto_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;

        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    auto_d        = 1'b0;
                    state_d       = REQ_ID;
                    avm_read_d    = 1'b1;
                    avm_address_d = 1'b0;
                    busy_d        = 1'b1;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                end
            end
            REQ_ID: begin
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    state_d    = WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (avm_readdatavalid) begin
                    id_value_d    = avm_readdata;
                    id_ok_d       = (avm_readdata == EXPECTED_ID);
                    state_d       = REQ_TS;
                    avm_read_d    = 1'b1;
                    avm_address_d = 1'b1;
                end
            end
            REQ_TS: begin
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    state_d    = WAIT_TS;
                end
            end
            WAIT_TS: begin
                if (avm_readdatavalid) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                    state_d    = FINISH;
                    done_d     = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                avm_read_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

`ifdef SYSID_CHECK_TIMEOUT_EN
        timeout_d = timeout_q;
        in_xfer   = (state_q == REQ_ID) || (state_q == WAIT_ID) ||
                    (state_q == REQ_TS) || (state_q == WAIT_TS);
        cnt_inc   = cnt_q + 16'd1;
        data_wins = ((state_q == WAIT_ID) || (state_q == WAIT_TS)) && avm_readdatavalid;

        if ((state_d != state_q) && ((state_d == REQ_ID) || (state_d == REQ_TS))) begin
            cnt_d = 16'd0;
        end else if (in_xfer) begin
            cnt_d = cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end

        if ((state_q == IDLE) && (state_d == REQ_ID)) begin
            timeout_d = 1'b0;
        end

        // A read completing on the limit cycle takes precedence over the abort.
        if (in_xfer && (cnt_inc == TMO_LIMIT) && !data_wins) begin
            state_d    = FINISH;
            avm_read_d = 1'b0;
            timeout_d  = 1'b1;
            done_d     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            auto_q        <= AUTO_START;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            cnt_q         <= 16'd0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            auto_q        <= auto_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
`ifdef SYSID_CHECK_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
`ifdef SYSID_CHECK_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb/tb_sysid_check_ctrl.sv - directed self-checking bench for sysid_check_ctrl.
// Set SYSID_CHECK_TIMEOUT_EN to also exercise the abort path with an 8-cycle limit.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_TS = 32'd1463451056;

    logic        clock             = 1'b0;
    logic        reset             = 1'b1;
    logic        start             = 1'b0;
    logic        avm_waitrequest   = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata      = 32'd0;
    logic        avm_address;
    logic        avm_read;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    int          stall_n   = 0;
    int          stall_cnt = 0;
    bit          pend      = 1'b0;
    logic        pend_addr = 1'b0;
    bit          drop_ts   = 1'b0;
    bit          inj       = 1'b0;
    logic [31:0] inj_data  = 32'd0;
    logic [31:0] mem0      = 32'd0;
    logic [31:0] mem1      = EXP_TS;
    logic        addr_log[$];
    int          done_cnt  = 0;

    sysid_check_ctrl #(
        .EXPECTED_ID   (32'd0),
        .EXPECTED_TS   (EXP_TS),
        .AUTO_START    (1'b1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata     (avm_readdata),
        .busy             (busy),
        .done             (done),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    // Slave model: stalls stall_n cycles per request, returns data one cycle after accept.
    always @(negedge clock) begin
        if (reset) begin
            pend              = 1'b0;
            stall_cnt         = 0;
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
        end else begin
            avm_readdatavalid = 1'b0;
            if (inj) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = inj_data;
                inj               = 1'b0;
            end else if (pend) begin
                pend = 1'b0;
                if (!(drop_ts && pend_addr)) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_addr ? mem1 : mem0;
                end
            end
            if (avm_read) begin
                if (stall_cnt < stall_n) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt       = 0;
                    pend            = 1'b1;
                    pend_addr       = avm_address;
                    addr_log.push_back(avm_address);
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt       = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        step;
        step;
        checks++;
        if ({busy, done, avm_read, avm_address} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/read/addr=%b want 0000", {busy, done, avm_read, avm_address});
        end
        checks++;
        if ({id_ok, ts_ok, timeout} !== 3'b000 || id_value !== 32'd0 || ts_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: ok/tmo=%b id=%h ts=%h want 000 0 0", {id_ok, ts_ok, timeout}, id_value, ts_value);
        end
        addr_log.delete();
        done_cnt = 0;
        reset = 1'b0;
        n = 0;
        while (n < 40) begin
            step;
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL auto_latency: done after %0d cycles want 5", n);
        end
        checks++;
        if (id_ok !== 1'b1 || ts_ok !== 1'b1 || id_value !== 32'd0 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL auto_values: id_ok=%b ts_ok=%b id=%h ts=%h want 1 1 0 %h", id_ok, ts_ok, id_value, ts_value, EXP_TS);
        end
        step;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_after: done=%b busy=%b want 0 0", done, busy);
        end
        repeat (5) step;
        checks++;
        if (done_cnt !== 1 || addr_log.size() !== 2 || addr_log[0] !== 1'b0 || addr_log[1] !== 1'b1) begin
            errors++;
            $display("FAIL auto_once: done_cnt=%0d reads=%0d want 1 done, reads 0,1", done_cnt, addr_log.size());
        end
    endtask

    task automatic test_id_mismatch;
        int n;
        mem0  = 32'h0000_0005;
        start = 1'b1;
        n = 0;
        while (n < 40) begin
            step;
            n++;
            start = 1'b0;
            if (done === 1'b1) break;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL mismatch_latency: done after %0d cycles want 5", n);
        end
        checks++;
        if (id_ok !== 1'b0 || id_value !== 32'd5 || ts_ok !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_values: id_ok=%b id=%h ts_ok=%b want 0 5 1", id_ok, id_value, ts_ok);
        end
        step;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_after: done=%b busy=%b want 0 0", done, busy);
        end
        mem0 = 32'd0;
    endtask

    task automatic test_stall;
        int   n;
        int   rd0;
        int   rd1;
        int   rises;
        logic prev;
        stall_n = 3;
        rd0 = 0;
        rd1 = 0;
        rises = 0;
        prev = 1'b0;
        start = 1'b1;
        n = 0;
        while (n < 60) begin
            step;
            n++;
            start = 1'b0;
            if (avm_read === 1'b1 && prev === 1'b0) rises++;
            if (avm_read === 1'b1) begin
                if (avm_address === 1'b1) rd1++;
                else rd0++;
            end
            prev = avm_read;
            if (done === 1'b1) break;
        end
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL stall_latency: done after %0d cycles want 11", n);
        end
        checks++;
        if (rd0 !== 4 || rd1 !== 4 || rises !== 2) begin
            errors++;
            $display("FAIL stall_hold: rd0=%0d rd1=%0d rises=%0d want 4 4 2", rd0, rd1, rises);
        end
        checks++;
        if (id_ok !== 1'b1 || ts_ok !== 1'b1 || id_value !== 32'd0 || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL stall_values: id_ok=%b ts_ok=%b id=%h ts=%h", id_ok, ts_ok, id_value, ts_value);
        end
`ifndef SYSID_CHECK_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL stall_timeout: timeout=%b want 0", timeout);
        end
`endif
        stall_n = 0;
        step;
    endtask

    task automatic test_start_drop;
        int n;
        int extra;
        done_cnt = 0;
        addr_log.delete();
        start = 1'b1;
        n = 0;
        while (n < 40) begin
            step;
            n++;
            start = (n == 3);
            if (n == 3) begin
                checks++;
                if (avm_read !== 1'b1 || avm_address !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_in_req_ts: read=%b addr=%b want 1 1", avm_read, avm_address);
                end
            end
            if (done === 1'b1) begin
                start = 1'b1;
                break;
            end
        end
        step;
        start = 1'b0;
        extra = 0;
        repeat (10) begin
            step;
            if (avm_read !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (done_cnt !== 1 || extra !== 0) begin
            errors++;
            $display("FAIL drop_once: done_cnt=%0d busy_cycles=%0d want 1 0", done_cnt, extra);
        end
        checks++;
        if (addr_log.size() !== 2 || addr_log[0] !== 1'b0 || addr_log[1] !== 1'b1) begin
            errors++;
            $display("FAIL drop_addrs: reads=%0d want addresses 0,1", addr_log.size());
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        checks++;
        if (busy !== 1'b1 || avm_read !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_id: busy=%b read=%b done=%b want 1 0 0", busy, avm_read, done);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || avm_read !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: busy=%b read=%b done=%b want 0 0 0", busy, avm_read, done);
        end
        done_cnt = 0;
        addr_log.delete();
        step;
        step;
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL mid_no_done: done_cnt=%0d want 0", done_cnt);
        end
        reset = 1'b0;
        n = 0;
        while (n < 40) begin
            step;
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (n !== 5 || id_ok !== 1'b1 || ts_ok !== 1'b1) begin
            errors++;
            $display("FAIL mid_rerun: latency=%0d id_ok=%b ts_ok=%b want 5 1 1", n, id_ok, ts_ok);
        end
        step;
        checks++;
        if (addr_log.size() !== 2 || addr_log[0] !== 1'b0 || addr_log[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_addrs: reads=%0d want addresses 0,1", addr_log.size());
        end
    endtask

    task automatic test_spurious;
        step;
        inj_data = 32'hDEAD_BEEF;
        inj = 1'b1;
        repeat (3) step;
        checks++;
        if (id_value !== 32'd0 || ts_value !== EXP_TS || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_rdv: id=%h ts=%h busy=%b done=%b want 0 %h 0 0", id_value, ts_value, busy, done, EXP_TS);
        end
    endtask

`ifdef SYSID_CHECK_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        int e;
        drop_ts = 1'b1;
        start = 1'b1;
        n = 0;
        e = -100;
        while (n < 60) begin
            step;
            n++;
            start = 1'b0;
            if (e < 0 && avm_read === 1'b1 && avm_address === 1'b1) e = n;
            if (done === 1'b1) break;
        end
        checks++;
        if (n - e !== 8) begin
            errors++;
            $display("FAIL tmo_latency: done %0d cycles after REQ_TS want 8", n - e);
        end
        checks++;
        if (timeout !== 1'b1 || ts_ok !== 1'b0 || id_ok !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flags: timeout=%b ts_ok=%b id_ok=%b want 1 0 1", timeout, ts_ok, id_ok);
        end
        inj_data = 32'h1234_5678;
        inj = 1'b1;
        repeat (3) step;
        checks++;
        if (ts_value !== EXP_TS || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late: ts=%h busy=%b want %h 0", ts_value, busy, EXP_TS);
        end
        drop_ts = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_id_mismatch;
        test_stall;
        test_start_drop;
        test_reset_mid;
        test_spurious;
`ifdef SYSID_CHECK_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
